// File: rtl/hwint_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hwint_controller                                                 |
// | Purpose : synchronised, maskable level/edge interrupt latch behind a       |
// |           4-word register window; drives the 6-bit HWInt vector to CP0.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hwint_controller #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_SRC-1:0] Src,
  input  logic             Sel,
  input  logic             WE,
  input  logic [31:0]      A,
  input  logic [31:0]      D,
  output logic [31:0]      Q,
  output logic             Err,
  output logic [5:0]       HWInt
);

  localparam logic [1:0] C_IDX_CTRL  = 2'd0;
  localparam logic [1:0] C_IDX_PEND  = 2'd1;
  localparam logic [1:0] C_IDX_RAW   = 2'd2;
  localparam logic [1:0] C_IDX_SWSET = 2'd3;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
  logic [N_SRC-1:0] r_sl_d;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_edge;
  logic [N_SRC-1:0] r_pend;
  logic [5:0]       r_hwint;

  logic [N_SRC-1:0] w_sl;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  logic [5:0]       w_vec;
  logic [1:0]       w_idx;
  logic             w_wr;
  logic             w_unused;

  assign w_idx    = A[3:2];
  assign Err      = Sel & (A[1:0] != 2'b00);
  assign w_wr     = Sel & WE & ~Err;
  assign w_unused = ^{A[31:4], D};

  assign w_sl   = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sl & ~r_sl_d;

  // Set beats clear, so a level line that is still high re-pends after W1C.
  assign w_set = (r_edge & w_rise) | (~r_edge & w_sl)
               | ((w_wr && w_idx == C_IDX_SWSET) ? D[N_SRC-1:0] : '0);
  assign w_clr = (w_wr && w_idx == C_IDX_PEND) ? D[N_SRC-1:0] : '0;

  always_comb begin
    w_vec = '0;
    w_vec[N_SRC-1:0] = r_pend & r_mask;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_sync  <= '0;
      r_sl_d  <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_pend  <= '0;
      r_hwint <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], Src};
      r_sl_d  <= w_sl;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_hwint <= w_vec;
      if (w_wr && w_idx == C_IDX_CTRL) begin
        r_mask <= D[N_SRC-1:0];
        r_edge <= D[8+N_SRC-1:8];
      end
    end
  end

  assign HWInt = r_hwint;

  always_comb begin
    Q = '0;
    if (Sel && !Err) begin
      case (w_idx)
        C_IDX_CTRL: begin
          Q[N_SRC-1:0]   = r_mask;
          Q[8+N_SRC-1:8] = r_edge;
        end
        C_IDX_PEND:  Q[N_SRC-1:0] = r_pend;
        C_IDX_RAW:   Q[N_SRC-1:0] = w_sl;
        default:     Q = '0;
      endcase
    end
  end

endmodule
`default_nettype wire
